// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer.
// Arbitrates a synchronous exception, NUM_IRQ prioritised level interrupts and
// mret in IDLE, then steps through the CSR side-effects one write per cycle and
// finishes with a single redirect cycle toward a target latched at accept time.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting; accept decision made combinationally here
//   W_MEPC    | write mepc  (0x341) with the latched pc
//   W_MCAUSE  | write mcause(0x342) with the latched cause
//   W_MTVAL   | write mtval (0x343) with the latched tval
//   W_MSTATUS | write mstatus: MPIE<-MIE, MIE<-0, MPP<-M
//   REDIR     | flush to the latched trap target, claim pulse for interrupts
//   R_MSTATUS | mret: write mstatus with MIE<-MPIE, MPIE<-1
//   R_REDIR   | mret: flush to the current mepc
module trap_ctrl #(
  parameter int NUM_IRQ        = 4,
  parameter int IRQ_CAUSE_BASE = 16,
  parameter bit VECTORED_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               commit_valid_i,
  input  logic [31:0]        pc_i,
  input  logic               exc_valid_i,
  input  logic [4:0]         exc_code_i,
  input  logic [31:0]        exc_tval_i,
  input  logic               mret_i,
  input  logic [31:0]        csr_mtvec_i,
  input  logic [31:0]        csr_mepc_i,
  input  logic [31:0]        csr_mstatus_i,
  output logic               csr_we_o,
  output logic [11:0]        csr_waddr_o,
  output logic [31:0]        csr_wdata_o,
  output logic               stallreq_o,
  output logic               flush_o,
  output logic [31:0]        redirect_pc_o,
  output logic [NUM_IRQ-1:0] irq_claim_o
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MTVAL   = 3'd3,
    W_MSTATUS = 3'd4,
    REDIR     = 3'd5,
    R_MSTATUS = 3'd6,
    R_REDIR   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        cause_q, cause_d;
  logic [31:0]        tval_q, tval_d;
  logic [31:0]        target_q, target_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic               is_irq_q, is_irq_d;

  logic [NUM_IRQ-1:0] irq_pend;
  logic               irq_found;
  logic [IDX_W-1:0]   irq_idx;
  logic [31:0]        irq_code;
  logic               take_exc, take_irq, take_ret, accept;
  logic [31:0]        mtvec_base;
  logic               vec_mode;
  logic [31:0]        mstatus_trap, mstatus_ret;

  // Fixed-priority encoder: the lowest-numbered enabled pending source wins.
  always_comb begin
    irq_pend  = irq_i & irq_en_i;
    irq_found = 1'b0;
    irq_idx   = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (irq_pend[k]) begin
        irq_found = 1'b1;
        irq_idx   = IDX_W'(k);
      end
    end
  end

  // Accept decision; only meaningful while IDLE. Exception beats interrupt beats mret.
  always_comb begin
    take_exc   = exc_valid_i;
    take_irq   = !exc_valid_i && commit_valid_i && csr_mstatus_i[3] && irq_found;
    take_ret   = !exc_valid_i && !take_irq && mret_i && commit_valid_i;
    accept     = take_exc || take_irq || take_ret;
    irq_code   = 32'(IRQ_CAUSE_BASE) + 32'(irq_idx);
    mtvec_base = {csr_mtvec_i[31:2], 2'b00};
    vec_mode   = VECTORED_EN && (csr_mtvec_i[1:0] == 2'b01);
  end

  // mstatus rewrites for trap entry and mret; MPP is left untouched on return.
  always_comb begin
    mstatus_trap        = csr_mstatus_i;
    mstatus_trap[7]     = csr_mstatus_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_ret         = csr_mstatus_i;
    mstatus_ret[3]      = csr_mstatus_i[7];
    mstatus_ret[7]      = 1'b1;
  end

  // State and latch register; reset aborts any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      target_q <= '0;
      src_q    <= '0;
      is_irq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      target_q <= target_d;
      src_q    <= src_d;
      is_irq_q <= is_irq_d;
    end
  end

  // Next-state and latch capture; inputs are ignored outside IDLE.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    target_d = target_q;
    src_d    = src_q;
    is_irq_d = is_irq_q;
    case (state_q)
      IDLE: begin
        if (take_exc) begin
          state_d  = W_MEPC;
          pc_d     = pc_i;
          cause_d  = {27'b0, exc_code_i};
          tval_d   = exc_tval_i;
          target_d = mtvec_base;
          src_d    = '0;
          is_irq_d = 1'b0;
        end else if (take_irq) begin
          state_d  = W_MEPC;
          pc_d     = pc_i;
          cause_d  = {1'b1, irq_code[30:0]};
          tval_d   = '0;
          target_d = vec_mode ? (mtvec_base + (irq_code << 2)) : mtvec_base;
          src_d    = irq_idx;
          is_irq_d = 1'b1;
        end else if (take_ret) begin
          state_d  = R_MSTATUS;
        end
      end
      W_MEPC:    state_d = W_MCAUSE;
      W_MCAUSE:  state_d = W_MTVAL;
      W_MTVAL:   state_d = W_MSTATUS;
      W_MSTATUS: state_d = REDIR;
      REDIR:     state_d = IDLE;
      R_MSTATUS: state_d = R_REDIR;
      R_REDIR:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register; stall also covers the accept cycle.
  always_comb begin
    csr_we_o      = 1'b0;
    csr_waddr_o   = '0;
    csr_wdata_o   = '0;
    flush_o       = 1'b0;
    redirect_pc_o = '0;
    irq_claim_o   = '0;
    stallreq_o    = (state_q != IDLE) || accept;
    case (state_q)
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = pc_q;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      W_MTVAL: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MTVAL;
        csr_wdata_o = tval_q;
      end
      W_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mstatus_trap;
      end
      REDIR: begin
        flush_o       = 1'b1;
        redirect_pc_o = target_q;
        if (is_irq_q) irq_claim_o = NUM_IRQ'(1) << src_q;
      end
      R_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = mstatus_ret;
      end
      R_REDIR: begin
        flush_o       = 1'b1;
        redirect_pc_o = csr_mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Parametrised machine-mode trap controller: arbitrates synchronous exceptions, NUM_IRQ prioritised level-sensitive interrupt sources and `mret`, then sequences the CSR side-effects and the pipeline redirect. Sits between the execute/LSU stage, `csr_reg` and `pipe_ctrl`. Adds over the previous generation:
- per-source enables and fixed priority;
- mtval write;
- vectored mtvec mode;
- per-source claim pulse;
- single redirect cycle carrying a latched target.

## Interface
Parameters:
- NUM_IRQ, 4, number of interrupt sources (1..16)
- IRQ_CAUSE_BASE, 16, mcause code of source 0; source k uses IRQ_CAUSE_BASE+k
- VECTORED_EN, 1, 1 = honour mtvec[1:0]==2'b01 vectored mode; 0 = always direct

Ports (clk/rst: one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- irq_i  in  NUM_IRQ  level interrupt lines
- irq_en_i  in  NUM_IRQ  per-source enable (mie bits)
- commit_valid_i  in  1  pc_i is a committable instruction boundary
- pc_i  in  32  address of that instruction
- exc_valid_i  in  1  synchronous exception on pc_i
- exc_code_i  in  5  exception cause code
- exc_tval_i  in  32  faulting address/instruction
- mret_i  in  1  mret at pc_i
- csr_mtvec_i / csr_mepc_i / csr_mstatus_i  in  32 each  current CSR values
- csr_we_o  out  1  CSR write enable
- csr_waddr_o  out  12  CSR address
- csr_wdata_o  out  32  CSR data
- stallreq_o  out  1  hold pipeline
- flush_o  out  1  redirect pulse
- redirect_pc_o  out  32  redirect target
- irq_claim_o  out  NUM_IRQ  one-hot pulse for the source being taken

## Operation
Accept decision (IDLE only), priority highest first:
1. `exc_valid_i` → trap, cause = {27'b0, exc_code_i}, tval = exc_tval_i.
2. `commit_valid_i` && mstatus.MIE (bit 3) && |(irq_i & irq_en_i) → interrupt. Lowest set index wins; cause = {1'b1, 31-bit IRQ_CAUSE_BASE+k}; tval = 0.
3. `mret_i` && `commit_valid_i` → return.

On accept, latch: pc_i, cause, tval, source index. Latch target:
- vectored interrupt (VECTORED_EN && mtvec[1:0]==01): {mtvec[31:2],2'b00} + 4·code;
- otherwise: {mtvec[31:2],2'b00}.

FSM states: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, REDIR, R_MSTATUS, R_REDIR.
- Trap path: IDLE → W_MEPC → W_MCAUSE → W_MTVAL → W_MSTATUS → REDIR → IDLE.
- Return path: IDLE → R_MSTATUS → R_REDIR → IDLE.

CSR writes (csr_we_o=1, decoded from the state register):
- W_MEPC: 0x341, latched pc.
- W_MCAUSE: 0x342, latched cause.
- W_MTVAL: 0x343, latched tval.
- W_MSTATUS: 0x300, csr_mstatus_i with MPIE(7) ← MIE(3), MIE ← 0, MPP(12:11) ← 2'b11.
- R_MSTATUS: 0x300, MIE ← MPIE, MPIE ← 1.

Redirect and claim:
- REDIR: flush_o=1, redirect_pc_o = latched target; irq_claim_o = one-hot of the latched source (interrupt traps only).
- R_REDIR: flush_o=1, redirect_pc_o = csr_mepc_i.

Outside write/redirect states, csr_we_o, csr_waddr_o, csr_wdata_o, flush_o, redirect_pc_o and irq_claim_o are all 0.

## Timing
- Reset: state IDLE, all latches 0, all outputs 0; asserting rst mid-sequence aborts immediately with no further CSR writes.
- stallreq_o is combinational: high in the accept cycle T (any condition 1–3 true) and in every non-IDLE state.
- Trap: writes in T+1..T+4, flush in T+5, stallreq_o high T..T+5, IDLE at T+6.
- Return: mstatus write T+1, flush T+2.
- Inputs ignored while not IDLE. irq_i dropping, exc_valid_i or mret_i arriving mid-sequence change nothing; a still-pending source is re-arbitrated only from IDLE.
- mtvec sampled only at accept. mstatus sampled in W_MSTATUS/R_MSTATUS. mepc sampled in R_REDIR.
- Simultaneous exception + interrupt + mret: exception taken, no claim pulse.
- irq_i set but irq_en_i bit clear, or MIE=0: no accept, stallreq_o low.

## Test plan
- ECALL-style: exc_valid_i=1, code=11, pc_i=0x80000100, tval=0, mtvec=0x80000000, mstatus=0x8 → writes mepc=0x80000100, mcause=0xB, mtval=0, mstatus=0x1880; flush at T+5 to 0x80000000.
- Priority: irq_i=4'b1010, irq_en_i=4'b1111, MIE=1, mtvec=0x80000001 → mcause=0x80000011, redirect 0x80000044, irq_claim_o=4'b0010 for one cycle.
- Masking: irq_i=4'b0001, irq_en_i=0 (then MIE=0 with enable set) → no csr_we_o, stallreq_o low for 20 cycles.
- Exception beats interrupt: exc_valid_i and irq_i[0] in the same cycle → mcause=exc_code_i, irq_claim_o stays 0.
- mret: mstatus=0x1880, mepc=0x80000104 → mstatus write 0x1888 at T+1, flush to 0x80000104 at T+2.
- rst pulsed at T+2 of a trap sequence → all outputs 0 next cycle, no mtval/mstatus writes, state IDLE.
